// File: rtl/comb_rd_pkg.sv
// rtl/comb_rd_pkg.sv - shared types and sizing helpers for the combinational read-port arbiter
package comb_rd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    RESP  = 2'd2
  } slot_state_e;

  localparam int MAX_RETRY_DEF = 3;

  // A MAX_RETRY of 0 still needs a 1-bit counter so the storage is never zero-width.
  function automatic int retry_cnt_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

  localparam int RETRY_CNT_W = retry_cnt_w(MAX_RETRY_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - pure round-robin pick of the first candidate at or after the pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         cand_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && cand_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = ($clog2(N))'(idx);
      end
    end
  end

endmodule

// File: rtl/comb_rd_port_arbiter.sv
// rtl/comb_rd_port_arbiter.sv - per-requester request slots sharing one combinational read port
module comb_rd_port_arbiter
  import comb_rd_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [NUM_REQ-1:0]        resp_ok,
  output logic [NUM_REQ*DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0]         raddr,
  output logic                      rvalid,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      rresp
);

  localparam int CW = retry_cnt_w(MAX_RETRY);
  localparam int IW = $clog2(NUM_REQ);

  slot_state_e       st_q   [NUM_REQ];
  slot_state_e       st_d   [NUM_REQ];
  logic [ADDR_W-1:0] addr_q [NUM_REQ];
  logic [ADDR_W-1:0] addr_d [NUM_REQ];
  logic [CW-1:0]     cnt_q  [NUM_REQ];
  logic [CW-1:0]     cnt_d  [NUM_REQ];
  logic [DATA_W-1:0] data_q [NUM_REQ];
  logic [DATA_W-1:0] data_d [NUM_REQ];
  logic [NUM_REQ-1:0] ok_q, ok_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .cand_i    (cand),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Port drive and slot status depend only on registered state, never on rdata/rresp.
  always_comb begin
    cand       = '0;
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i]                      = (st_q[i] == PEND);
      req_ready[i]                 = (st_q[i] != PEND);
      resp_valid[i]                = (st_q[i] == RESP);
      resp_data[i*DATA_W +: DATA_W] = data_q[i];
    end
    resp_ok = ok_q;
    rvalid  = |gnt;
    raddr   = rvalid ? addr_q[gnt_idx] : '0;
  end

  always_comb begin
    ok_d = ok_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      st_d[i]   = st_q[i];
      addr_d[i] = addr_q[i];
      cnt_d[i]  = cnt_q[i];
      data_d[i] = data_q[i];
      case (st_q[i])
        PEND: begin
          if (gnt[i]) begin
            if (rresp) begin
              st_d[i]   = RESP;
              data_d[i] = rdata;
              ok_d[i]   = 1'b1;
            end else if (cnt_q[i] < CW'(MAX_RETRY)) begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
              st_d[i]   = RESP;
              data_d[i] = '0;
              ok_d[i]   = 1'b0;
            end
          end
        end
        RESP:    st_d[i] = EMPTY;
        default: st_d[i] = EMPTY;
      endcase
      // A slot in RESP may take a new request in its pulse cycle, so reissue has no bubble.
      if (req_valid[i] && req_ready[i]) begin
        st_d[i]   = PEND;
        addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
        cnt_d[i]  = '0;
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (rvalid) begin
      if (int'(gnt_idx) == NUM_REQ - 1) rr_ptr_d = '0;
      else                              rr_ptr_d = gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        st_q[i]   <= EMPTY;
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
        data_q[i] <= '0;
      end
      ok_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
        cnt_q[i]  <= cnt_d[i];
        data_q[i] <= data_d[i];
      end
      ok_q     <= ok_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_comb_rd_port_arbiter.sv
// tb/tb_comb_rd_port_arbiter.sv - directed and randomized checks of the shared read-port arbiter
module tb_comb_rd_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MR = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ok;
  logic [N*DW-1:0] resp_data;
  logic [AW-1:0]   raddr;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  logic            rresp;

  int n_tests = 0;
  int n_fail  = 0;

  comb_rd_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ok    (resp_ok),
    .resp_data  (resp_data),
    .raddr      (raddr),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rresp      (rresp)
  );

  always #5 clock = ~clock;

  // Lookup port: addr 2 -> 10, addr 4 -> 20, anything else misses with junk data.
  always_comb begin
    rresp = 1'b0;
    rdata = 8'hEE;
    if (rvalid && raddr == 4'd2) begin rresp = 1'b1; rdata = 8'd10; end
    if (rvalid && raddr == 4'd4) begin rresp = 1'b1; rdata = 8'd20; end
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({req_ready, rvalid, raddr, resp_valid} !== {4'hF, 1'b0, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected %h", {req_ready, rvalid, raddr, resp_valid}, {4'hF, 1'b0, 4'h0, 4'h0});
    end
    n_tests++;
    if ({resp_ok, resp_data} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h expected 0", {resp_ok, resp_data});
    end
    set_addr(1, 4'd7);
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    n_tests++;
    if ({rvalid, raddr} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL reset_pre_pend: got %h expected %h", {rvalid, raddr}, {1'b1, 4'd7});
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, rvalid, raddr} !== {4'hF, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", {req_ready, rvalid, raddr}, {4'hF, 1'b0, 4'h0});
    end
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if ({resp_valid, rvalid} !== 5'h0) begin
        n_fail++;
        $display("FAIL reset_no_resp cyc%0d: got %h expected 0", c, {resp_valid, rvalid});
      end
      cyc();
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    set_addr(0, 4'd2);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    n_tests++;
    if ({rvalid, raddr, resp_valid} !== {1'b1, 4'd2, 4'h0}) begin
      n_fail++;
      $display("FAIL hit_grant: got %h expected %h", {rvalid, raddr, resp_valid}, {1'b1, 4'd2, 4'h0});
    end
    cyc();
    n_tests++;
    if ({resp_valid, resp_ok[0], resp_data[7:0], rvalid} !== {4'b0001, 1'b1, 8'd10, 1'b0}) begin
      n_fail++;
      $display("FAIL hit_resp: got %h expected %h", {resp_valid, resp_ok[0], resp_data[7:0], rvalid}, {4'b0001, 1'b1, 8'd10, 1'b0});
    end
    cyc();
    n_tests++;
    if ({resp_valid, resp_ok[0], resp_data[7:0]} !== {4'b0000, 1'b1, 8'd10}) begin
      n_fail++;
      $display("FAIL hit_pulse_end: got %h expected %h", {resp_valid, resp_ok[0], resp_data[7:0]}, {4'b0000, 1'b1, 8'd10});
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] exp_rv;
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, 4'd4);
    req_valid = 4'hF;
    cyc();
    req_valid = '0;
    for (int k = 0; k <= N; k++) begin
      exp_rv = (k == 0) ? 4'h0 : 4'(1 << (k - 1));
      n_tests++;
      if ({rvalid, raddr, resp_valid} !== {(k < N), (k < N) ? 4'd4 : 4'd0, exp_rv}) begin
        n_fail++;
        $display("FAIL rr_order step%0d: got %h expected %h", k, {rvalid, raddr, resp_valid}, {(k < N), (k < N) ? 4'd4 : 4'd0, exp_rv});
      end
      if (k > 0) begin
        n_tests++;
        if ({resp_ok[k-1], resp_data[(k-1)*DW +: DW]} !== {1'b1, 8'd20}) begin
          n_fail++;
          $display("FAIL rr_data req%0d: got %h expected %h", k - 1, {resp_ok[k-1], resp_data[(k-1)*DW +: DW]}, {1'b1, 8'd20});
        end
      end
      cyc();
    end
  endtask

  task automatic test_retry_exhaust();
    do_reset();
    set_addr(1, 4'd7);
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    for (int k = 0; k <= MR; k++) begin
      n_tests++;
      if ({rvalid, raddr, resp_valid} !== {1'b1, 4'd7, 4'h0}) begin
        n_fail++;
        $display("FAIL retry_grant%0d: got %h expected %h", k, {rvalid, raddr, resp_valid}, {1'b1, 4'd7, 4'h0});
      end
      cyc();
    end
    n_tests++;
    if ({rvalid, resp_valid, resp_ok[1], resp_data[15:8]} !== {1'b0, 4'b0010, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL retry_fail_resp: got %h expected %h", {rvalid, resp_valid, resp_ok[1], resp_data[15:8]}, {1'b0, 4'b0010, 1'b0, 8'd0});
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_addr(0, 4'd2);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    cyc();
    n_tests++;
    if ({resp_valid[0], req_ready[0], resp_data[7:0]} !== {1'b1, 1'b1, 8'd10}) begin
      n_fail++;
      $display("FAIL b2b_resp1: got %h expected %h", {resp_valid[0], req_ready[0], resp_data[7:0]}, {1'b1, 1'b1, 8'd10});
    end
    set_addr(0, 4'd4);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    n_tests++;
    if ({rvalid, raddr, resp_valid} !== {1'b1, 4'd4, 4'h0}) begin
      n_fail++;
      $display("FAIL b2b_grant2: got %h expected %h", {rvalid, raddr, resp_valid}, {1'b1, 4'd4, 4'h0});
    end
    cyc();
    n_tests++;
    if ({resp_valid, resp_ok[0], resp_data[7:0]} !== {4'b0001, 1'b1, 8'd20}) begin
      n_fail++;
      $display("FAIL b2b_resp2: got %h expected %h", {resp_valid, resp_ok[0], resp_data[7:0]}, {4'b0001, 1'b1, 8'd20});
    end
    cyc();
  endtask

  task automatic test_alternate();
    logic [AW-1:0] exp_a;
    logic          exp_r3;
    do_reset();
    set_addr(2, 4'd7);
    set_addr(3, 4'd4);
    req_valid = 4'b1100;
    cyc();
    req_valid = 4'b1000;
    for (int k = 1; k <= 7; k++) begin
      exp_a  = (k % 2 == 1) ? 4'd7 : 4'd4;
      exp_r3 = (k >= 3) && (k % 2 == 1);
      n_tests++;
      if ({rvalid, raddr, resp_valid[3], resp_valid[2]} !== {1'b1, exp_a, exp_r3, 1'b0}) begin
        n_fail++;
        $display("FAIL alt_cyc%0d: got %h expected %h", k, {rvalid, raddr, resp_valid[3], resp_valid[2]}, {1'b1, exp_a, exp_r3, 1'b0});
      end
      if (exp_r3) begin
        n_tests++;
        if ({resp_ok[3], resp_data[31:24]} !== {1'b1, 8'd20}) begin
          n_fail++;
          $display("FAIL alt_data3 cyc%0d: got %h expected %h", k, {resp_ok[3], resp_data[31:24]}, {1'b1, 8'd20});
        end
      end
      if (k == 7) req_valid = '0;
      cyc();
    end
    n_tests++;
    if ({rvalid, resp_valid, resp_ok[2], resp_data[23:16]} !== {1'b0, 4'b0100, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL alt_fail2: got %h expected %h", {rvalid, resp_valid, resp_ok[2], resp_data[23:16]}, {1'b0, 4'b0100, 1'b0, 8'd0});
    end
    cyc();
  endtask

  // Reference: each requester either waits with an outstanding address or is free;
  // each cycle the first waiting requester at/after the pointer uses the port.
  task automatic test_random();
    int            waiting [N];
    int            misses  [N];
    int            pulse   [N];
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_data  [N];
    logic          m_ok    [N];
    int            ptr;
    int            g;
    int            sel;
    logic [N-1:0]    e_ready, e_pulse, e_ok;
    logic [N*DW-1:0] e_data;
    logic [AW-1:0]   e_addr;
    logic [AW-1:0]   a;
    do_reset();
    ptr = 0;
    for (int i = 0; i < N; i++) begin
      waiting[i] = 0; misses[i] = 0; pulse[i] = 0;
      m_addr[i] = '0; m_data[i] = '0; m_ok[i] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && waiting[(ptr + k) % N] != 0) g = (ptr + k) % N;
      e_addr = '0;
      if (g >= 0) e_addr = m_addr[g];
      for (int i = 0; i < N; i++) begin
        e_ready[i] = (waiting[i] == 0);
        e_pulse[i] = (pulse[i] != 0);
        e_ok[i]    = m_ok[i];
        e_data[i*DW +: DW] = m_data[i];
      end
      n_tests++;
      if (req_ready !== e_ready) begin
        n_fail++;
        $display("FAIL rand_ready cyc%0d: got %h expected %h", c, req_ready, e_ready);
      end
      n_tests++;
      if ({rvalid, raddr} !== {(g >= 0), e_addr}) begin
        n_fail++;
        $display("FAIL rand_port cyc%0d: got %h expected %h", c, {rvalid, raddr}, {(g >= 0), e_addr});
      end
      n_tests++;
      if ({resp_valid, resp_ok, resp_data} !== {e_pulse, e_ok, e_data}) begin
        n_fail++;
        $display("FAIL rand_resp cyc%0d: got %h expected %h", c, {resp_valid, resp_ok, resp_data}, {e_pulse, e_ok, e_data});
      end

      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        sel = $urandom_range(0, 3);
        a = (sel == 0) ? 4'd2 : (sel == 1) ? 4'd4 : 4'($urandom_range(0, 15));
        set_addr(i, a);
      end

      for (int i = 0; i < N; i++) pulse[i] = 0;
      if (g >= 0) begin
        if (m_addr[g] == 4'd2 || m_addr[g] == 4'd4) begin
          waiting[g] = 0; pulse[g] = 1; m_ok[g] = 1'b1;
          m_data[g] = (m_addr[g] == 4'd2) ? 8'd10 : 8'd20;
        end else if (misses[g] < MR) begin
          misses[g]++;
        end else begin
          waiting[g] = 0; pulse[g] = 1; m_ok[g] = 1'b0; m_data[g] = 8'd0;
        end
        ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (e_ready[i] && req_valid[i]) begin
          waiting[i] = 1;
          misses[i]  = 0;
          m_addr[i]  = req_addr[i*AW +: AW];
        end
      end
      cyc();
    end
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_single_hit();
    test_all_four();
    test_retry_exhaust();
    test_back_to_back();
    test_alternate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
